// File: rtl/bridge_input_arbiter.sv
// Packet-granular round-robin arbiter feeding one AXI4-Stream bridge slave port.
// One source owns the output until its tlast is accepted; beats pass through a single register.
module bridge_input_arbiter #(
  parameter int unsigned C_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned NUM_INPUTS         = 4,
  parameter int unsigned NUM_INPUTS_WIDTH   = $clog2(NUM_INPUTS)
) (
  input  logic                                          clk,
  input  logic                                          resetn,
  input  logic [NUM_INPUTS*C_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic [NUM_INPUTS*C_AXIS_DATA_WIDTH/8-1:0]     s_axis_tstrb,
  input  logic [NUM_INPUTS*C_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
  input  logic [NUM_INPUTS-1:0]                         s_axis_tvalid,
  input  logic [NUM_INPUTS-1:0]                         s_axis_tlast,
  output logic [NUM_INPUTS-1:0]                         s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]                  m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]                m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]                 m_axis_tuser,
  output logic                                          m_axis_tvalid,
  output logic                                          m_axis_tlast,
  input  logic                                          m_axis_tready,
  output logic [NUM_INPUTS_WIDTH-1:0]                   grant_idx,
  output logic                                          busy
);

  localparam int unsigned DW = C_AXIS_DATA_WIDTH;
  localparam int unsigned SW = C_AXIS_DATA_WIDTH / 8;
  localparam int unsigned UW = C_AXIS_TUSER_WIDTH;

  typedef enum logic [0:0] {StIdle, StPkt} state_e;

  state_e                      state_q;
  logic [NUM_INPUTS_WIDTH-1:0] rr_ptr_q, grant_q, grant_next;
  logic [NUM_INPUTS_WIDTH-1:0] pick_idx, cand_idx;
  logic [31:0]                 cand;
  logic                        pick_found, out_free, accept;

  logic [DW-1:0] sel_data;
  logic [SW-1:0] sel_strb;
  logic [UW-1:0] sel_user;
  logic          sel_valid, sel_last;

  logic [DW-1:0] m_data_q;
  logic [SW-1:0] m_strb_q;
  logic [UW-1:0] m_user_q;
  logic          m_valid_q, m_last_q;

  // The output register can take a new beat if empty or being drained this cycle.
  assign out_free = !m_valid_q || m_axis_tready;

  // Round-robin search starting at rr_ptr_q, wrapping modulo NUM_INPUTS.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    cand_idx   = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      cand     = (32'(rr_ptr_q) + i) % NUM_INPUTS;
      cand_idx = cand[NUM_INPUTS_WIDTH-1:0];
      if (!pick_found && s_axis_tvalid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_strb  = '0;
    sel_user  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      if (grant_q == NUM_INPUTS_WIDTH'(k)) begin
        sel_data  = s_axis_tdata[k*DW +: DW];
        sel_strb  = s_axis_tstrb[k*SW +: SW];
        sel_user  = s_axis_tuser[k*UW +: UW];
        sel_valid = s_axis_tvalid[k];
        sel_last  = s_axis_tlast[k];
      end
    end
  end

  always_comb begin
    s_axis_tready = '0;
    if (state_q == StPkt && out_free) begin
      s_axis_tready[grant_q] = 1'b1;
    end
  end

  assign accept     = (state_q == StPkt) && out_free && sel_valid;
  assign grant_next = (grant_q == NUM_INPUTS_WIDTH'(NUM_INPUTS - 1)) ? '0
                                                                    : grant_q + NUM_INPUTS_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= StIdle;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
      m_strb_q  <= '0;
      m_user_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (pick_found && out_free) begin
            grant_q <= pick_idx;
            state_q <= StPkt;
          end
        end
        StPkt: begin
          if (accept && sel_last) begin
            state_q  <= StIdle;
            rr_ptr_q <= grant_next;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (accept) begin
        m_valid_q <= 1'b1;
        m_data_q  <= sel_data;
        m_strb_q  <= sel_strb;
        m_user_q  <= sel_user;
        m_last_q  <= sel_last;
      end else if (m_axis_tready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = m_data_q;
  assign m_axis_tstrb  = m_strb_q;
  assign m_axis_tuser  = m_user_q;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tlast  = m_last_q;
  assign grant_idx     = grant_q;
  assign busy          = (state_q == StPkt);

endmodule

// File: tb/tb_bridge_input_arbiter.sv
// Bench for bridge_input_arbiter: queue-driven sources, a transaction-level model checked
// every cycle, and directed scenarios with hand-computed packet orders and timings.
module tb_bridge_input_arbiter;

  localparam int NI = 4;
  localparam int IW = 2;
  localparam int DW = 256;
  localparam int SW = DW / 8;
  localparam int UW = 128;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  logic              clk;
  logic              resetn;
  logic [NI*DW-1:0]  s_tdata;
  logic [NI*SW-1:0]  s_tstrb;
  logic [NI*UW-1:0]  s_tuser;
  logic [NI-1:0]     s_tvalid, s_tlast, s_tready;
  logic [DW-1:0]     m_tdata;
  logic [SW-1:0]     m_tstrb;
  logic [UW-1:0]     m_tuser;
  logic              m_tvalid, m_tlast, m_tready;
  logic [IW-1:0]     grant_idx;
  logic              busy;

  bridge_input_arbiter #(
    .C_AXIS_DATA_WIDTH (DW),
    .C_AXIS_TUSER_WIDTH(UW),
    .NUM_INPUTS        (NI),
    .NUM_INPUTS_WIDTH  (IW)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .s_axis_tdata (s_tdata),
    .s_axis_tstrb (s_tstrb),
    .s_axis_tuser (s_tuser),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tlast (s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tstrb (m_tstrb),
    .m_axis_tuser (m_tuser),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tlast (m_tlast),
    .m_axis_tready(m_tready),
    .grant_idx    (grant_idx),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;
  int cyc   = 0;

  // Source queues: each input replays its beats in order while enabled and not stalled.
  beat_t         src_mem [NI][16];
  int            src_hd [NI];
  int            src_n  [NI];
  logic [NI-1:0] src_en, src_stall, acc_seen;

  // Observation logs: output handshakes and grant decisions.
  logic [31:0] out_w[$];
  bit          out_l[$];
  int          out_c[$];
  int          grants[$];

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic beat_t mk_beat(input int k, input int pkt, input int b, input bit last);
    beat_t r;
    r.data = {8{8'(k), 8'(pkt), 8'h00, 8'(b)}};
    r.strb = {4{8'(b * 37 + k)}};
    r.user = {4{32'((k << 8) | b)}};
    r.last = last;
    return r;
  endfunction

  function automatic int rr_first(input int ptr, input logic [NI-1:0] v);
    for (int i = 0; i < NI; i++) if (v[(ptr + i) % NI]) return (ptr + i) % NI;
    return -1;
  endfunction

  task automatic load_pkt(input int k, input int pkt, input int nb);
    for (int b = 1; b <= nb; b++) begin
      src_mem[k][src_n[k]] = mk_beat(k, pkt, b, b == nb);
      src_n[k]++;
    end
  endtask

  task automatic clear_srcs();
    for (int k = 0; k < NI; k++) begin
      src_hd[k] = 0;
      src_n[k]  = 0;
    end
  endtask

  task automatic clear_logs();
    out_w.delete();
    out_l.delete();
    out_c.delete();
    grants.delete();
  endtask

  task automatic drive();
    beat_t b;
    for (int k = 0; k < NI; k++) begin
      if (src_en[k] && !src_stall[k] && src_hd[k] < src_n[k]) begin
        b           = src_mem[k][src_hd[k]];
        s_tvalid[k] = 1'b1;
      end else begin
        b           = '0;
        s_tvalid[k] = 1'b0;
      end
      s_tdata[k*DW +: DW] = b.data;
      s_tstrb[k*SW +: SW] = b.strb;
      s_tuser[k*UW +: UW] = b.user;
      s_tlast[k]          = b.last;
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) if (acc_seen[k]) src_hd[k]++;
      drive();
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    clear_srcs();
    src_en    = '0;
    src_stall = '0;
    drive();
    run(2);
    resetn = 1'b1;
    run(1);
  endtask

  function automatic logic [31:0] ow(input int i);
    return (i < out_w.size()) ? out_w[i] : 32'hDEAD_BEEF;
  endfunction
  function automatic int oc(input int i);
    return (i < out_c.size()) ? out_c[i] : -1000;
  endfunction
  function automatic int gr(input int i);
    return (i < grants.size()) ? grants[i] : -1;
  endfunction
  function automatic logic [31:0] word(input int k, input int pkt, input int b);
    return {8'(k), 8'(pkt), 8'h00, 8'(b)};
  endfunction

  task automatic chk_out(input string name, input int i, input logic [31:0] w, input bit l);
    chk({name, "_data"}, 512'(ow(i)), 512'(w));
    chk({name, "_last"}, 512'((i < out_l.size()) ? out_l[i] : 1'bx), 512'(l));
  endtask

  // ---------------------------------------------------------------------------------------------
  // Model: the output register holds the last accepted beat until drained; busy follows the
  // IDLE/PKT rules; a new grant goes to the first valid input after the last packet's owner.
  logic          p_rst, p_busy, p_mvalid, p_mready, started;
  logic [IW-1:0] p_grant;
  logic [NI-1:0] p_valid, p_acc;
  beat_t         p_in [NI];
  beat_t         exp_b, cur_b;
  logic          exp_v, exp_busy;
  logic [NI-1:0] exp_rdy;
  int            mptr, ek;

  initial begin
    started  = 1'b0;
    acc_seen = '0;
    exp_v    = 1'b0;
    exp_b    = '0;
    mptr     = 0;
    forever begin
      @(negedge clk);
      cyc++;
      cur_b = '{data: m_tdata, strb: m_tstrb, user: m_tuser, last: m_tlast};
      if (started) begin
        if (!p_rst) begin
          exp_v    = 1'b0;
          exp_b    = '0;
          mptr     = 0;
          exp_busy = 1'b0;
          chk("grant_rst", 512'(grant_idx), 512'(0));
        end else begin
          exp_busy = p_busy ? !(|(p_acc & {p_in[3].last, p_in[2].last, p_in[1].last,
                                           p_in[0].last}))
                            : ((|p_valid) && (!p_mvalid || p_mready));
          if (!p_busy && busy) begin
            ek = rr_first(mptr, p_valid);
            chk("grant", 512'(grant_idx), 512'(ek));
            grants.push_back(int'(grant_idx));
          end else if (p_busy && busy) begin
            chk("grant_hold", 512'(grant_idx), 512'(p_grant));
          end
          if (|p_acc) begin
            ek = 0;
            for (int k = NI - 1; k >= 0; k--) if (p_acc[k]) ek = k;
            exp_v = 1'b1;
            exp_b = p_in[ek];
            if (p_in[ek].last) mptr = (ek + 1) % NI;
          end else if (p_mvalid && p_mready) begin
            exp_v = 1'b0;
          end
        end
        chk("busy", 512'(busy), 512'(exp_busy));
        chk("m_tvalid", 512'(m_tvalid), 512'(exp_v));
        if (exp_v || !p_rst) chk("m_beat", 512'(cur_b), 512'(exp_b));
        exp_rdy = '0;
        if (busy && (!m_tvalid || m_tready)) exp_rdy[grant_idx] = 1'b1;
        chk("s_tready", 512'(s_tready), 512'(exp_rdy));
      end
      if (m_tvalid && m_tready) begin
        out_w.push_back(m_tdata[31:0]);
        out_l.push_back(m_tlast);
        out_c.push_back(cyc);
      end
      started  = 1'b1;
      p_rst    = resetn;
      p_busy   = busy;
      p_mvalid = m_tvalid;
      p_mready = m_tready;
      p_grant  = grant_idx;
      p_valid  = s_tvalid;
      p_acc    = resetn ? (s_tvalid & s_tready) : '0;
      acc_seen = p_acc;
      for (int k = 0; k < NI; k++) begin
        p_in[k] = '{data: s_tdata[k*DW +: DW], strb: s_tstrb[k*SW +: SW],
                    user: s_tuser[k*UW +: UW], last: s_tlast[k]};
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  int en_cyc;
  int order3 [3];

  initial begin
    resetn    = 1'b0;
    m_tready  = 1'b1;
    src_en    = '0;
    src_stall = '0;
    s_tdata   = '0;
    s_tstrb   = '0;
    s_tuser   = '0;
    s_tvalid  = '0;
    s_tlast   = '0;
    clear_srcs();
    drive();

    // Reset then idle
    run(3);
    resetn = 1'b1;
    run(2);
    chk("t1_m_tvalid", 512'(m_tvalid), 512'(0));
    chk("t1_s_tready", 512'(s_tready), 512'(0));
    chk("t1_busy", 512'(busy), 512'(0));
    chk("t1_grant", 512'(grant_idx), 512'(0));

    // Single source, input 2, three beats
    clear_logs();
    load_pkt(2, 0, 3);
    src_en = 4'b0100;
    drive();
    en_cyc = cyc;
    run(10);
    chk("t2_ngrants", 512'(grants.size()), 512'(1));
    chk("t2_grant", 512'(gr(0)), 512'(2));
    chk("t2_nbeats", 512'(out_w.size()), 512'(3));
    for (int i = 0; i < 3; i++) chk_out("t2_beat", i, word(2, 0, i + 1), i == 2);
    chk("t2_latency", 512'(oc(0) - en_cyc), 512'(3));
    chk("t2_fullrate", 512'(oc(2) - oc(0)), 512'(2));

    // Round-robin over inputs 0, 1, 3 with two 2-beat packets each
    do_reset();
    clear_logs();
    for (int p = 0; p < 2; p++) begin
      load_pkt(0, p, 2);
      load_pkt(1, p, 2);
      load_pkt(3, p, 2);
    end
    src_en = 4'b1011;
    drive();
    run(30);
    order3[0] = 0;
    order3[1] = 1;
    order3[2] = 3;
    chk("t3_nbeats", 512'(out_w.size()), 512'(12));
    for (int i = 0; i < 6; i++) chk("t3_grant", 512'(gr(i)), 512'(order3[i % 3]));
    for (int i = 0; i < 12; i++) begin
      chk_out("t3_beat", i, word(order3[(i / 2) % 3], i / 6, i % 2 + 1), i % 2 == 1);
    end
    for (int i = 1; i < 12; i++) chk("t3_gap", 512'(oc(i) - oc(i - 1)), 512'((i % 2) ? 1 : 2));

    // Backpressure for 5 cycles mid-packet from input 1
    clear_srcs();
    clear_logs();
    load_pkt(1, 0, 4);
    src_en = 4'b0010;
    drive();
    en_cyc = cyc;
    run(2);
    m_tready = 1'b0;
    run(5);
    m_tready = 1'b1;
    run(10);
    chk("t4_nbeats", 512'(out_w.size()), 512'(4));
    for (int i = 0; i < 4; i++) chk_out("t4_beat", i, word(1, 0, i + 1), i == 3);
    chk("t4_first_out", 512'(oc(0) - en_cyc), 512'(8));
    chk("t4_resume", 512'(oc(3) - oc(0)), 512'(3));

    // Granted input 0 stalls for 4 cycles while input 1 waits
    clear_srcs();
    clear_logs();
    load_pkt(0, 0, 4);
    load_pkt(1, 1, 2);
    src_en = 4'b0011;
    drive();
    run(2);
    src_stall = 4'b0001;
    drive();
    run(4);
    src_stall = '0;
    drive();
    run(20);
    chk("t5_ngrants", 512'(grants.size()), 512'(2));
    chk("t5_grant0", 512'(gr(0)), 512'(0));
    chk("t5_grant1", 512'(gr(1)), 512'(1));
    chk("t5_nbeats", 512'(out_w.size()), 512'(6));
    for (int i = 0; i < 4; i++) chk_out("t5_in0", i, word(0, 0, i + 1), i == 3);
    for (int i = 0; i < 2; i++) chk_out("t5_in1", i + 4, word(1, 1, i + 1), i == 1);
    chk("t5_stall_gap", 512'(oc(1) - oc(0)), 512'(5));

    // Reset on beat 2 of 4, then arbitration restarts from pointer 0
    clear_srcs();
    clear_logs();
    load_pkt(2, 0, 4);
    src_en = 4'b0100;
    drive();
    run(3);
    resetn = 1'b0;
    clear_srcs();
    src_en = '0;
    drive();
    run(2);
    chk("t6_rst_busy", 512'(busy), 512'(0));
    chk("t6_rst_grant", 512'(grant_idx), 512'(0));
    chk("t6_rst_tvalid", 512'(m_tvalid), 512'(0));
    chk("t6_rst_tdata", 512'(m_tdata), 512'(0));
    resetn = 1'b1;
    clear_logs();
    load_pkt(3, 5, 1);
    load_pkt(1, 5, 2);
    src_en = 4'b1010;
    drive();
    run(12);
    chk("t6_grant0", 512'(gr(0)), 512'(1));
    chk("t6_grant1", 512'(gr(1)), 512'(3));
    chk("t6_nbeats", 512'(out_w.size()), 512'(3));
    chk_out("t6_b0", 0, word(1, 5, 1), 1'b0);
    chk_out("t6_b1", 1, word(1, 5, 2), 1'b1);
    chk_out("t6_b2", 2, word(3, 5, 1), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
